// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, encodings and helpers for the SHA-256 message feeder
package sha256_pkg;

    localparam int BLOCK_W = 512;
    localparam int STATE_W = 256;
    localparam int WORDS   = 16;

    // H0 sits in the low word, H7 in the high word
    localparam logic [STATE_W-1:0] SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PAD   = 3'd2,
        ST_XFORM = 3'd3,
        ST_DONE  = 3'd4
    } feed_state_e;

    // What the next PAD visit has to write
    typedef enum logic [1:0] {
        PAD_NONE  = 2'd0,
        PAD_FIRST = 2'd1,
        PAD_LEN   = 2'd2,
        PAD_MARK  = 2'd3
    } pad_kind_e;

    // Length words in lane order: byte 56 (bit-length MSB) lands in lane 0 of word 14
    function automatic logic [31:0] len_word(input logic [63:0] bits, input logic hi);
        if (hi) begin
            len_word = {bits[39:32], bits[47:40], bits[55:48], bits[63:56]};
        end else begin
            len_word = {bits[7:0], bits[15:8], bits[23:16], bits[31:24]};
        end
    endfunction

endpackage

// File: rtl/sha256_pad_lane.sv
// rtl/sha256_pad_lane.sv - masks unused lanes of the last word and drops the 0x80 marker after the data
module sha256_pad_lane (
    input  logic [31:0] word_i,
    input  logic        last_i,
    input  logic [1:0]  bytes_i,
    output logic [31:0] word_o
);

    // bytes_i == 0 means a full last word; its marker goes into the following word
    always_comb begin
        word_o = word_i;
        if (last_i && (bytes_i != 2'd0)) begin
            for (int k = 0; k < 4; k++) begin
                if (k == int'(bytes_i)) begin
                    word_o[8*k +: 8] = 8'h80;
                end else if (k > int'(bytes_i)) begin
                    word_o[8*k +: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/sha256_msg_feeder.sv
// rtl/sha256_msg_feeder.sv - packs a byte stream into padded SHA-256 blocks and chains transform results
module sha256_msg_feeder
    import sha256_pkg::*;
#(
    parameter int XFORM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [1:0]         s_bytes,
    output logic [BLOCK_W-1:0] xf_block,
    output logic [STATE_W-1:0] xf_state,
    input  logic [STATE_W-1:0] xf_result,
    output logic [STATE_W-1:0] digest,
    output logic               digest_valid,
    output logic               busy
);

    feed_state_e              state_q, state_d;
    pad_kind_e                pad_q, pad_d;
    logic [WORDS-1:0][31:0]   block_q, block_d, pad_block;
    logic [STATE_W-1:0]       hstate_q, hstate_d;
    logic [STATE_W-1:0]       digest_q, digest_d;
    logic [63:0]              bytes_q, bytes_d;
    logic [3:0]               widx_q, widx_d;
    logic [7:0]               lat_q, lat_d;
    logic                     last_seen_q, last_seen_d;

    logic [31:0]              lane_word;
    logic                     take;
    logic [2:0]               word_bytes;
    logic [63:0]              bit_len;
    logic [5:0]               n_mod;
    logic [3:0]               last_w;

    sha256_pad_lane u_pad_lane (
        .word_i  (s_data),
        .last_i  (s_last),
        .bytes_i (s_bytes),
        .word_o  (lane_word)
    );

    assign s_ready      = (state_q == ST_IDLE) || (state_q == ST_FILL);
    assign take         = s_valid && s_ready;
    assign word_bytes   = (s_last && (s_bytes != 2'd0)) ? {1'b0, s_bytes} : 3'd4;
    assign bit_len      = bytes_q << 3;
    assign n_mod        = bytes_q[5:0];
    assign last_w       = 4'((n_mod - 6'd1) >> 2);

    assign xf_block     = block_q;
    assign xf_state     = hstate_q;
    assign digest       = digest_q;
    assign busy         = (state_q != ST_IDLE);

    // Padding rewrite of the whole block; n_mod == 0 on the first pass means the block is pure data
    always_comb begin
        pad_block = block_q;
        for (int i = 0; i < WORDS; i++) begin
            if (pad_q == PAD_FIRST) begin
                if ((n_mod != 6'd0) && (i > int'(last_w))) begin
                    pad_block[i] = ((i == int'(last_w) + 1) && (n_mod[1:0] == 2'd0))
                                   ? 32'h0000_0080 : 32'h0000_0000;
                end
            end else begin
                pad_block[i] = ((i == 0) && (pad_q == PAD_MARK)) ? 32'h0000_0080 : 32'h0000_0000;
            end
        end
        if ((pad_q != PAD_FIRST) || ((n_mod != 6'd0) && (n_mod <= 6'd55))) begin
            pad_block[14] = len_word(bit_len, 1'b1);
            pad_block[15] = len_word(bit_len, 1'b0);
        end
    end

    always_comb begin
        state_d      = state_q;
        pad_d        = pad_q;
        block_d      = block_q;
        hstate_d     = hstate_q;
        digest_d     = digest_q;
        bytes_d      = bytes_q;
        widx_d       = widx_q;
        lat_d        = lat_q;
        last_seen_d  = last_seen_q;
        digest_valid = 1'b0;

        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (take) begin
                    block_d[widx_q] = lane_word;
                    widx_d          = widx_q + 4'd1;
                    bytes_d         = ((state_q == ST_IDLE) ? 64'd0 : bytes_q) + 64'(word_bytes);
                    if (state_q == ST_IDLE) begin
                        digest_d = '0;
                    end
                    if (s_last) begin
                        last_seen_d = 1'b1;
                        pad_d       = PAD_FIRST;
                        state_d     = ST_PAD;
                    end else if (widx_q == 4'd15) begin
                        lat_d   = '0;
                        state_d = ST_XFORM;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_PAD: begin
                block_d = pad_block;
                lat_d   = '0;
                state_d = ST_XFORM;
                if (pad_q == PAD_FIRST) begin
                    pad_d = (n_mod == 6'd0) ? PAD_MARK :
                            ((n_mod >= 6'd56) ? PAD_LEN : PAD_NONE);
                end else begin
                    pad_d = PAD_NONE;
                end
            end
            ST_XFORM: begin
                if (lat_q == 8'(XFORM_LAT - 1)) begin
                    hstate_d = xf_result;
                    if (!last_seen_q) begin
                        state_d = ST_FILL;
                    end else if (pad_q != PAD_NONE) begin
                        state_d = ST_PAD;
                    end else begin
                        digest_d = xf_result;
                        state_d  = ST_DONE;
                    end
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                hstate_d     = SHA256_IV;
                widx_d       = '0;
                last_seen_d  = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pad_q       <= PAD_NONE;
            block_q     <= '0;
            hstate_q    <= SHA256_IV;
            digest_q    <= '0;
            bytes_q     <= '0;
            widx_q      <= '0;
            lat_q       <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pad_q       <= pad_d;
            block_q     <= block_d;
            hstate_q    <= hstate_d;
            digest_q    <= digest_d;
            bytes_q     <= bytes_d;
            widx_q      <= widx_d;
            lat_q       <= lat_d;
            last_seen_q <= last_seen_d;
        end
    end

endmodule
